mem_arbiter: RTL and testbench

- Shares one external single-ported memory between the core's instruction-fetch requester and data-access requester (unified memory for FPGA deployment).
- Fixed-priority arbitration: data first, with a starvation guard for fetch. Allows one outstanding transaction.
- Memory has fixed read latency. The arbiter sequences issue, counts latency, and routes the response back to the owning requester.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Unified-memory arbiter: data/fetch requesters share one memory port.
// Fixed data priority with a fetch starvation guard, one outstanding access.
module mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [3:0]            d_be_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            owner_q, owner_d;
  logic            we_q, we_d;

  logic            resp;
  logic            arb_en;
  logic            starve;
  logic            d_win;
  logic            i_win;

  // Response slot, arbitration window and winner selection.
  always_comb begin
    resp   = (state_q == BUSY) && (cnt_q == '0);
    arb_en = !rst && ((state_q == IDLE) || resp);
    starve = (streak_q == STREAK_MAX);
    d_win  = arb_en && d_req_i && (!i_req_i || !starve);
    i_win  = arb_en && i_req_i && !d_win;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a grant always opens a BUSY window.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_win || i_win) state_d = BUSY;
      end
      BUSY: begin
        if (resp) state_d = (d_win || i_win) ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transaction bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      streak_q <= '0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
    end
  end

  // Latency count, owner capture and data-grant streak tracking.
  always_comb begin
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    we_d     = we_q;
    streak_d = streak_q;
    if (d_win || i_win) begin
      cnt_d   = CNT_LOAD;
      owner_d = d_win;
      we_d    = d_win && d_we_i;
    end else if ((state_q == BUSY) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (!i_req_i || i_win) begin
      streak_d = '0;
    end else if (d_win && !starve) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Outputs: memory strobe mirrors the winner, response routed to owner.
  always_comb begin
    i_gnt_o     = i_win;
    d_gnt_o     = d_win;
    mem_req_o   = d_win || i_win;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = 4'h0;
    mem_wdata_o = '0;
    i_rvalid_o  = resp && !owner_q;
    d_rvalid_o  = resp && owner_q;
    i_rdata_o   = '0;
    d_rdata_o   = '0;
    unique case (1'b1)
      d_win: begin
        mem_we_o    = d_we_i;
        mem_addr_o  = d_addr_i;
        mem_be_o    = d_be_i;
        mem_wdata_o = d_wdata_i;
      end
      i_win: begin
        mem_addr_o = i_addr_i;
        mem_be_o   = 4'hF;
      end
      default: ;
    endcase
    if (i_rvalid_o) i_rdata_o = mem_rdata_i;
    if (d_rvalid_o && !we_q) d_rdata_o = mem_rdata_i;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency-1 and latency-3 instances
// share stimulus; each scenario checks the instance it targets.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata;

  logic        a_i_gnt, a_i_rvalid, a_d_gnt, a_d_rvalid;
  logic [31:0] a_i_rdata, a_d_rdata;
  logic        a_mreq, a_mwe;
  logic [31:0] a_maddr, a_mwdata;
  logic [3:0]  a_mbe;

  logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid;
  logic [31:0] b_i_rdata, b_d_rdata;
  logic        b_mreq, b_mwe;
  logic [31:0] b_maddr, b_mwdata;
  logic [3:0]  b_mbe;

  int vecs;
  int miss;

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_l1 (
    .clk(clk), .rst(rst),
    .i_req_i(i_req), .i_addr_i(i_addr),
    .i_gnt_o(a_i_gnt), .i_rvalid_o(a_i_rvalid), .i_rdata_o(a_i_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr),
    .d_be_i(d_be), .d_wdata_i(d_wdata),
    .d_gnt_o(a_d_gnt), .d_rvalid_o(a_d_rvalid), .d_rdata_o(a_d_rdata),
    .mem_req_o(a_mreq), .mem_we_o(a_mwe), .mem_addr_o(a_maddr),
    .mem_be_o(a_mbe), .mem_wdata_o(a_mwdata), .mem_rdata_i(mem_rdata)
  );

  mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_l3 (
    .clk(clk), .rst(rst),
    .i_req_i(i_req), .i_addr_i(i_addr),
    .i_gnt_o(b_i_gnt), .i_rvalid_o(b_i_rvalid), .i_rdata_o(b_i_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr),
    .d_be_i(d_be), .d_wdata_i(d_wdata),
    .d_gnt_o(b_d_gnt), .d_rvalid_o(b_d_rvalid), .d_rdata_o(b_d_rdata),
    .mem_req_o(b_mreq), .mem_we_o(b_mwe), .mem_addr_o(b_maddr),
    .mem_be_o(b_mbe), .mem_wdata_o(b_mwdata), .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1, outputs are sampled at the negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_be    = '0;
    d_wdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    i_req = 1'b1;
    d_req = 1'b1;
    d_addr = 32'h55;
    sample();
    vecs++;
    if ({a_i_gnt, a_d_gnt, a_mreq, a_i_rvalid, a_d_rvalid} !== 5'b0) begin
      miss++;
      $display("FAIL reset_ctl: got %b want 00000",
               {a_i_gnt, a_d_gnt, a_mreq, a_i_rvalid, a_d_rvalid});
    end
    vecs++;
    if ({a_maddr, a_mbe, a_mwdata, a_i_rdata, a_d_rdata} !== '0) begin
      miss++;
      $display("FAIL reset_data: addr %h be %h wd %h ird %h drd %h want 0",
               a_maddr, a_mbe, a_mwdata, a_i_rdata, a_d_rdata);
    end
    next_cycle();
    clear_inputs();
    rst = 1'b0;
    sample();
    vecs++;
    if ({a_mreq, a_i_rvalid, a_d_rvalid, a_maddr} !== '0) begin
      miss++;
      $display("FAIL reset_after: req %b irv %b drv %b addr %h want 0",
               a_mreq, a_i_rvalid, a_d_rvalid, a_maddr);
    end
    next_cycle();
  endtask

  task automatic test_fetch();
    do_reset();
    mem_rdata = 32'hDEADBEEF;
    i_req = 1'b1;
    i_addr = 32'h100;
    sample();
    vecs++;
    if ({a_i_gnt, a_d_gnt, a_mreq, a_mwe} !== 4'b1010
        || a_maddr !== 32'h100) begin
      miss++;
      $display("FAIL fetch_issue: gnt %b/%b req %b we %b addr %h want 1/0 1 0 100",
               a_i_gnt, a_d_gnt, a_mreq, a_mwe, a_maddr);
    end
    next_cycle();
    clear_inputs();
    sample();
    vecs++;
    if (a_i_rvalid !== 1'b1 || a_i_rdata !== 32'hDEADBEEF
        || a_d_rvalid !== 1'b0 || a_d_rdata !== 32'h0) begin
      miss++;
      $display("FAIL fetch_resp: irv %b ird %h drv %b drd %h want 1 deadbeef 0 0",
               a_i_rvalid, a_i_rdata, a_d_rvalid, a_d_rdata);
    end
    next_cycle();
  endtask

  task automatic test_write();
    do_reset();
    mem_rdata = 32'hDEADBEEF;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'h2004;
    d_be = 4'b1100;
    d_wdata = 32'h12345678;
    sample();
    vecs++;
    if ({a_d_gnt, a_i_gnt, a_mreq, a_mwe} !== 4'b1011 || a_maddr !== 32'h2004
        || a_mbe !== 4'b1100 || a_mwdata !== 32'h12345678) begin
      miss++;
      $display("FAIL write_issue: gnt %b req %b we %b addr %h be %b wd %h",
               a_d_gnt, a_mreq, a_mwe, a_maddr, a_mbe, a_mwdata);
    end
    next_cycle();
    clear_inputs();
    sample();
    vecs++;
    if (a_d_rvalid !== 1'b1 || a_d_rdata !== 32'h0 || a_i_rvalid !== 1'b0) begin
      miss++;
      $display("FAIL write_ack: drv %b drd %h irv %b want 1 0 0",
               a_d_rvalid, a_d_rdata, a_i_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_data_read();
    do_reset();
    mem_rdata = 32'hCAFEF00D;
    d_req = 1'b1;
    d_addr = 32'h40;
    d_be = 4'hF;
    d_wdata = 32'hFFFFFFFF;
    sample();
    vecs++;
    if (a_d_gnt !== 1'b1 || a_mwe !== 1'b0 || a_maddr !== 32'h40) begin
      miss++;
      $display("FAIL dread_issue: gnt %b we %b addr %h want 1 0 40",
               a_d_gnt, a_mwe, a_maddr);
    end
    next_cycle();
    clear_inputs();
    sample();
    vecs++;
    if (a_d_rvalid !== 1'b1 || a_d_rdata !== 32'hCAFEF00D
        || a_i_rdata !== 32'h0) begin
      miss++;
      $display("FAIL dread_resp: drv %b drd %h ird %h want 1 cafef00d 0",
               a_d_rvalid, a_d_rdata, a_i_rdata);
    end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    do_reset();
    mem_rdata = 32'h0BADF00D;
    i_req = 1'b1;
    i_addr = 32'h300;
    d_req = 1'b1;
    d_addr = 32'h400;
    d_be = 4'hF;
    sample();
    vecs++;
    if (b_d_gnt !== 1'b1 || b_i_gnt !== 1'b0 || b_maddr !== 32'h400) begin
      miss++;
      $display("FAIL sim_t0: dgnt %b ignt %b addr %h want 1 0 400",
               b_d_gnt, b_i_gnt, b_maddr);
    end
    next_cycle();
    d_req = 1'b0;
    d_addr = '0;
    for (int k = 1; k <= 2; k++) begin
      sample();
      vecs++;
      if ({b_i_gnt, b_d_gnt, b_mreq, b_d_rvalid} !== 4'b0) begin
        miss++;
        $display("FAIL sim_busy%0d: ignt %b dgnt %b req %b drv %b want 0",
                 k, b_i_gnt, b_d_gnt, b_mreq, b_d_rvalid);
      end
      next_cycle();
    end
    sample();
    vecs++;
    if (b_d_rvalid !== 1'b1 || b_i_gnt !== 1'b1 || b_maddr !== 32'h300
        || b_d_rdata !== 32'h0BADF00D) begin
      miss++;
      $display("FAIL sim_t3: drv %b ignt %b addr %h drd %h want 1 1 300 0badf00d",
               b_d_rvalid, b_i_gnt, b_maddr, b_d_rdata);
    end
    next_cycle();
    clear_inputs();
    for (int k = 4; k <= 5; k++) begin
      sample();
      vecs++;
      if (b_i_rvalid !== 1'b0) begin
        miss++;
        $display("FAIL sim_early%0d: irv %b want 0", k, b_i_rvalid);
      end
      next_cycle();
    end
    sample();
    vecs++;
    if (b_i_rvalid !== 1'b1 || b_i_rdata !== 32'h0BADF00D) begin
      miss++;
      $display("FAIL sim_t6: irv %b ird %h want 1 0badf00d",
               b_i_rvalid, b_i_rdata);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic exp_d;
    do_reset();
    i_req = 1'b1;
    i_addr = 32'hA0;
    d_req = 1'b1;
    d_addr = 32'hB0;
    d_be = 4'hF;
    for (int k = 0; k < 10; k++) begin
      exp_d = ((k % 5) != 4);
      sample();
      vecs++;
      if (a_d_gnt !== exp_d || a_i_gnt !== !exp_d) begin
        miss++;
        $display("FAIL starve_c%0d: dgnt %b ignt %b want %b %b",
                 k, a_d_gnt, a_i_gnt, exp_d, !exp_d);
      end
      next_cycle();
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_midop();
    do_reset();
    mem_rdata = 32'h11112222;
    d_req = 1'b1;
    d_addr = 32'h80;
    d_be = 4'hF;
    sample();
    vecs++;
    if (b_d_gnt !== 1'b1) begin
      miss++;
      $display("FAIL midop_gnt: dgnt %b want 1", b_d_gnt);
    end
    next_cycle();
    clear_inputs();
    rst = 1'b1;
    sample();
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      vecs++;
      if ({b_d_rvalid, b_i_rvalid, b_mreq, b_d_gnt, b_i_gnt} !== 5'b0
          || b_d_rdata !== 32'h0 || b_maddr !== 32'h0) begin
        miss++;
        $display("FAIL midop_c%0d: drv %b irv %b req %b drd %h addr %h want 0",
                 k, b_d_rvalid, b_i_rvalid, b_mreq, b_d_rdata, b_maddr);
      end
      next_cycle();
    end
  endtask

  task automatic test_idle_gap();
    do_reset();
    i_req = 1'b1;
    i_addr = 32'hC0;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'hD0;
    d_be = 4'h3;
    d_wdata = 32'h77;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
    end
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      sample();
      if (k > 0) begin
        vecs++;
        if ({a_mreq, a_mwe, a_mbe, a_maddr, a_mwdata} !== '0) begin
          miss++;
          $display("FAIL gap_c%0d: req %b we %b be %h addr %h wd %h want 0",
                   k, a_mreq, a_mwe, a_mbe, a_maddr, a_mwdata);
        end
      end
      next_cycle();
    end
    i_req = 1'b1;
    i_addr = 32'hC0;
    d_req = 1'b1;
    d_addr = 32'hD4;
    d_be = 4'hF;
    sample();
    vecs++;
    if (a_d_gnt !== 1'b1 || a_i_gnt !== 1'b0) begin
      miss++;
      $display("FAIL gap_streak: dgnt %b ignt %b want 1 0", a_d_gnt, a_i_gnt);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    vecs = 0;
    miss = 0;
    rst = 1'b1;
    mem_rdata = '0;
    clear_inputs();
    #1;
    test_reset();
    test_fetch();
    test_write();
    test_data_read();
    test_simultaneous();
    test_starvation();
    test_reset_midop();
    test_idle_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t limit 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
